// File: rtl/data_mem_resp_if.sv
// -----------------------------------------------------------------------------
// data_mem_resp_if
// Data-port bus between the MIPS core (master) and the data-memory responder
// (slave).
//   ena    core -> mem  access request, held stable while stall=1
//   wea    core -> mem  byte write enables, all-zero = read
//   addr   core -> mem  byte address
//   wdata  core -> mem  write data
//   rdata  mem -> core  read data, valid with ack
//   ack    mem -> core  one-cycle completion pulse
//   err    mem -> core  misaligned-access flag, valid with ack
//   stall  mem -> core  ena & ~ack
// -----------------------------------------------------------------------------
interface data_mem_resp_if;
   logic        ena;
   logic [3:0]  wea;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        err;
   logic        stall;

   modport master (
      output ena, wea, addr, wdata,
      input  rdata, ack, err, stall
   );

   modport slave (
      input  ena, wea, addr, wdata,
      output rdata, ack, err, stall
   );
endinterface

// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
// Memory-side responder for the core's data port. Holds a word-addressed
// register-array memory of 2^DEPTH_LOG2 32-bit words and completes each access
// LATENCY cycles after it is accepted, stalling the core meanwhile.
// Parameters:
//   DEPTH_LOG2  log2 of the number of 32-bit words
//   LATENCY     cycles from acceptance to completion (1..15)
// Ports:
//   clka  clock, rising edge
//   rst   asynchronous active-high reset
//   bus   data_mem_resp_if.slave (ena/wea/addr/wdata in, rdata/ack/err/stall out)
// -----------------------------------------------------------------------------
module data_mem_resp #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input  logic           clka,
   input  logic           rst,
   data_mem_resp_if.slave bus
);

   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t                  state;
   logic [3:0]              cnt;
   logic                    ack_q;
   logic                    err_q;
   logic [31:0]             rdata_q;

   // captured request
   logic [3:0]              wea_q;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic [31:0]             wdata_q;
   logic                    mis_q;

   logic [31:0]             mem [DEPTH];

   // operands of the access performed on the edge entering ACK
   logic                    complete;
   logic [3:0]              acc_wea;
   logic [DEPTH_LOG2-1:0]   acc_idx;
   logic [31:0]             acc_wdata;
   logic                    acc_mis;
   logic [31:0]             merged;

   logic                    unused_addr;

   assign unused_addr = ^{bus.addr[31:DEPTH_LOG2+2]};

   // With LATENCY=1 the access completes on the accepting edge, so it has to
   // use the live bus fields; otherwise the captured copy is used and bus
   // changes while BUSY have no effect.
   always_comb begin
      complete  = 1'b0;
      acc_wea   = wea_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_mis   = mis_q;
      if (state == IDLE) begin
         acc_wea   = bus.wea;
         acc_idx   = bus.addr[DEPTH_LOG2+1:2];
         acc_wdata = bus.wdata;
         acc_mis   = (bus.addr[1:0] != 2'b00);
         complete  = bus.ena && (LATENCY == 1);
      end else if (state == BUSY) begin
         // the edge that takes the counter to zero is the one entering ACK
         complete  = (cnt == 4'd1);
      end
   end

   always_comb begin
      merged = mem[acc_idx];
      for (int b = 0; b < 4; b++) begin
         if (acc_wea[b]) begin
            merged[8*b +: 8] = acc_wdata[8*b +: 8];
         end
      end
   end

   // Request capture. Pure data, loaded only when a request is accepted.
   always_ff @(posedge clka) begin
      if (state == IDLE && bus.ena) begin
         wea_q   <= bus.wea;
         idx_q   <= bus.addr[DEPTH_LOG2+1:2];
         wdata_q <= bus.wdata;
         mis_q   <= (bus.addr[1:0] != 2'b00);
      end
   end

   // Control FSM, registered outputs and memory update. The memory array sits
   // in the reset process only so that a write pending at reset is dropped;
   // its contents are never cleared.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         ack_q <= 1'b0;

         if (complete) begin
            ack_q <= 1'b1;
            err_q <= acc_mis;
            if (acc_mis) begin
               rdata_q <= 32'd0;
            end else if (acc_wea == 4'b0000) begin
               rdata_q <= mem[acc_idx];
            end else begin
               mem[acc_idx] <= merged;
            end
         end

         case (state)
            IDLE: begin
               if (bus.ena) begin
                  cnt   <= CNT_LOAD;
                  state <= (LATENCY > 1) ? BUSY : ACK;
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= ACK;
               end
            end
            // the request still on the bus here is the one just completed
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.ack   = ack_q;
   assign bus.err   = err_q;
   assign bus.stall = bus.ena & ~ack_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_data_mem_resp
// Bench for data_mem_resp: three instances (LATENCY 2, 1, 15) on one clock and
// one reset, each with its own bus interface. A word-array reference model per
// instance predicts rdata/err; access timing is predicted from LATENCY.
// -----------------------------------------------------------------------------
module tb_data_mem_resp;

   logic clka = 1'b0;
   logic rst;
   always #5 clka = ~clka;

   data_mem_resp_if bus0 ();
   data_mem_resp_if bus1 ();
   data_mem_resp_if bus2 ();

   data_mem_resp #(.DEPTH_LOG2(8), .LATENCY(2))  dut0 (.clka(clka), .rst(rst), .bus(bus0.slave));
   data_mem_resp #(.DEPTH_LOG2(8), .LATENCY(1))  dut1 (.clka(clka), .rst(rst), .bus(bus1.slave));
   data_mem_resp #(.DEPTH_LOG2(8), .LATENCY(15)) dut2 (.clka(clka), .rst(rst), .bus(bus2.slave));

   logic        ena_d   [3];
   logic [3:0]  wea_d   [3];
   logic [31:0] addr_d  [3];
   logic [31:0] wdata_d [3];
   logic [31:0] rdata_o [3];
   logic        ack_o   [3];
   logic        err_o   [3];
   logic        stall_o [3];

   assign bus0.ena = ena_d[0]; assign bus0.wea = wea_d[0]; assign bus0.addr = addr_d[0]; assign bus0.wdata = wdata_d[0];
   assign bus1.ena = ena_d[1]; assign bus1.wea = wea_d[1]; assign bus1.addr = addr_d[1]; assign bus1.wdata = wdata_d[1];
   assign bus2.ena = ena_d[2]; assign bus2.wea = wea_d[2]; assign bus2.addr = addr_d[2]; assign bus2.wdata = wdata_d[2];
   assign rdata_o[0] = bus0.rdata; assign ack_o[0] = bus0.ack; assign err_o[0] = bus0.err; assign stall_o[0] = bus0.stall;
   assign rdata_o[1] = bus1.rdata; assign ack_o[1] = bus1.ack; assign err_o[1] = bus1.err; assign stall_o[1] = bus1.stall;
   assign rdata_o[2] = bus2.rdata; assign ack_o[2] = bus2.ack; assign err_o[2] = bus2.err; assign stall_o[2] = bus2.stall;

   int lat [3] = '{2, 1, 15};

   // reference model: memory words and last completed rdata/err per instance
   logic [31:0] mm     [3][256];
   logic [31:0] exp_rd [3];
   logic        exp_er [3];

   int total = 0;
   int bad   = 0;

   task automatic model_apply(input int s, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
      int i;
      i = int'(a[9:2]);
      if (a[1:0] != 2'b00) begin
         exp_rd[s] = 32'd0;
         exp_er[s] = 1'b1;
      end else begin
         exp_er[s] = 1'b0;
         if (we == 4'b0000) exp_rd[s] = mm[s][i];
         else for (int b = 0; b < 4; b++) if (we[b]) mm[s][i][8*b +: 8] = wd[8*b +: 8];
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 3; s++) begin
         exp_rd[s] = 32'd0;
         exp_er[s] = 1'b0;
      end
   endtask

   // Drives one access on instance s and reports what was seen. after_ack: the
   // previous access left ena high and we are in its ACK cycle, so this request
   // is accepted one cycle later. keep: leave ena high after ack. drop_k: cycle
   // at which ena is dropped and fields scrambled (0 = never). nowait: present
   // in the current cycle instead of waiting for the next idle cycle.
   task automatic access(input int s, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd,
                         input bit after_ack, input bit keep, input int drop_k, input bit nowait,
                         output logic [31:0] rd, output logic er, output int ack_at, output bit stall_ok);
      int  o;
      bit  dropped;
      logic want_stall;
      o       = after_ack ? 1 : 0;
      dropped = 1'b0;
      if (!after_ack && !nowait) @(negedge clka);
      ena_d[s] = 1'b1; wea_d[s] = we; addr_d[s] = a; wdata_d[s] = wd;
      ack_at = -1; stall_ok = 1'b1; rd = 32'd0; er = 1'b0;
      #1;
      if (o == 0 && stall_o[s] !== 1'b1) stall_ok = 1'b0;
      for (int k = 1; k <= lat[s] + o + 3; k++) begin
         @(negedge clka);
         if (k == drop_k) begin
            ena_d[s] = 1'b0; wea_d[s] = 4'($urandom); addr_d[s] = $urandom; wdata_d[s] = $urandom;
            dropped = 1'b1;
         end
         #1;
         want_stall = (k < lat[s] + o) && !dropped;
         if (stall_o[s] !== want_stall) stall_ok = 1'b0;
         if (ack_o[s] === 1'b1) begin
            ack_at = k; rd = rdata_o[s]; er = err_o[s];
            break;
         end
      end
      if (!keep) ena_d[s] = 1'b0;
      model_apply(s, we, a, wd);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int s = 0; s < 3; s++) begin
         ena_d[s] = 1'b0; wea_d[s] = 4'h0; addr_d[s] = 32'd0; wdata_d[s] = 32'd0;
      end
      model_reset();
      repeat (3) @(negedge clka);
      #1;
      for (int s = 0; s < 3; s++) begin
         total++;
         if (ack_o[s] !== 1'b0 || err_o[s] !== 1'b0 || rdata_o[s] !== 32'd0 || stall_o[s] !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs dut%0d: got ack=%b err=%b rdata=%h stall=%b want all zero",
                     s, ack_o[s], err_o[s], rdata_o[s], stall_o[s]);
         end
      end
      ena_d[0] = 1'b1;
      #1;
      total++;
      if (stall_o[0] !== 1'b1) begin
         bad++;
         $display("FAIL reset_stall_follows_ena: got %b want 1", stall_o[0]);
      end
      ena_d[0] = 1'b0;
      @(negedge clka);
      rst = 1'b0;
   endtask

   task automatic check_access(input string name, input int s, input int o, input logic [31:0] rd, input logic er,
                               input int at, input bit sok, input logic [31:0] want_rd, input logic want_er);
      // thin reporting wrapper kept local to the directed tests
      total++;
      if (at !== lat[s] + o || sok !== 1'b1) begin
         bad++;
         $display("FAIL %s timing dut%0d: got ack_at=%0d stall_ok=%b want ack_at=%0d stall_ok=1", name, s, at, sok, lat[s] + o);
      end
      total++;
      if (rd !== want_rd || er !== want_er) begin
         bad++;
         $display("FAIL %s data dut%0d: got rdata=%h err=%b want rdata=%h err=%b", name, s, rd, er, want_rd, want_er);
      end
   endtask

   task automatic test_basic();
      logic [31:0] rd; logic er; int at; bit sok;
      access(0, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, rd, er, at, sok);
      check_access("write_10", 0, 0, rd, er, at, sok, 32'd0, 1'b0);
      access(0, 4'h0, 32'h10, 32'h0, 0, 0, 0, 0, rd, er, at, sok);
      check_access("read_10", 0, 0, rd, er, at, sok, 32'hDEADBEEF, 1'b0);
   endtask

   task automatic test_byte_enables();
      logic [31:0] rd; logic er; int at; bit sok;
      access(0, 4'hF, 32'h20, 32'h11223344, 0, 0, 0, 0, rd, er, at, sok);
      access(0, 4'b0101, 32'h20, 32'hAABBCCDD, 0, 0, 0, 0, rd, er, at, sok);
      check_access("partial_write", 0, 0, rd, er, at, sok, 32'hDEADBEEF, 1'b0);
      access(0, 4'h0, 32'h20, 32'h0, 0, 0, 0, 0, rd, er, at, sok);
      check_access("read_merged", 0, 0, rd, er, at, sok, 32'h11BB33DD, 1'b0);
   endtask

   task automatic test_misaligned();
      logic [31:0] rd; logic er; int at; bit sok;
      access(0, 4'hF, 32'h21, 32'hFFFFFFFF, 0, 0, 0, 0, rd, er, at, sok);
      check_access("misaligned_write", 0, 0, rd, er, at, sok, 32'd0, 1'b1);
      access(0, 4'h0, 32'h20, 32'h0, 0, 0, 0, 0, rd, er, at, sok);
      check_access("read_after_misaligned", 0, 0, rd, er, at, sok, 32'h11BB33DD, 1'b0);
   endtask

   task automatic test_wrap();
      logic [31:0] rd; logic er; int at; bit sok;
      access(0, 4'hF, 32'h400, 32'h5A5A5A5A, 0, 0, 0, 0, rd, er, at, sok);
      access(0, 4'h0, 32'h000, 32'h0, 0, 0, 0, 0, rd, er, at, sok);
      check_access("wrap_read_0", 0, 0, rd, er, at, sok, 32'h5A5A5A5A, 1'b0);
   endtask

   task automatic test_latency_extremes();
      logic [31:0] rd; logic er; int at; bit sok;
      access(1, 4'hF, 32'h44, 32'hCAFEF00D, 0, 0, 0, 0, rd, er, at, sok);
      access(1, 4'h0, 32'h44, 32'h0, 0, 0, 0, 0, rd, er, at, sok);
      check_access("lat1_read", 1, 0, rd, er, at, sok, 32'hCAFEF00D, 1'b0);
      access(2, 4'hF, 32'h48, 32'h01234567, 0, 0, 0, 0, rd, er, at, sok);
      access(2, 4'h0, 32'h48, 32'h0, 0, 0, 0, 0, rd, er, at, sok);
      check_access("lat15_read", 2, 0, rd, er, at, sok, 32'h01234567, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er; int at; bit sok;
      logic [31:0] vals [4];
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 4; i++) vals[i] = $urandom;
         for (int i = 0; i < 8; i++) begin
            access(s, (i < 4) ? 4'hF : 4'h0, 32'h80 + 32'(4 * (i % 4)), vals[i % 4],
                   i > 0, i < 7, 0, 0, rd, er, at, sok);
            total++;
            if (at !== lat[s] + ((i > 0) ? 1 : 0) || sok !== 1'b1) begin
               bad++;
               $display("FAIL b2b timing dut%0d #%0d: got ack_at=%0d stall_ok=%b want ack_at=%0d",
                        s, i, at, sok, lat[s] + ((i > 0) ? 1 : 0));
            end
            if (i >= 4) begin
               total++;
               if (rd !== vals[i % 4] || er !== 1'b0) begin
                  bad++;
                  $display("FAIL b2b read dut%0d #%0d: got %h err=%b want %h err=0", s, i, rd, er, vals[i % 4]);
               end
            end
         end
      end
   endtask

   task automatic test_drop_while_busy();
      logic [31:0] rd; logic er; int at; bit sok;
      for (int s = 0; s < 3; s += 2) begin
         access(s, 4'hF, 32'hC0, 32'h600DCAFE, 0, 0, 1, 0, rd, er, at, sok);
         total++;
         if (at !== lat[s] || sok !== 1'b1) begin
            bad++;
            $display("FAIL drop_busy timing dut%0d: got ack_at=%0d stall_ok=%b want ack_at=%0d", s, at, sok, lat[s]);
         end
         access(s, 4'h0, 32'hC0, 32'h0, 0, 0, 0, 0, rd, er, at, sok);
         check_access("read_after_drop", s, 0, rd, er, at, sok, 32'h600DCAFE, 1'b0);
      end
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] rd; logic er; int at; bit sok;
      access(2, 4'hF, 32'h3, 32'h0, 0, 0, 0, 0, rd, er, at, sok);
      access(0, 4'hF, 32'h30, 32'h0BADF00D, 0, 0, 0, 0, rd, er, at, sok);
      access(0, 4'h0, 32'h30, 32'h0, 0, 0, 0, 0, rd, er, at, sok);
      @(negedge clka);
      ena_d[0] = 1'b1; wea_d[0] = 4'hF; addr_d[0] = 32'h30; wdata_d[0] = 32'h12345678;
      @(negedge clka);
      rst = 1'b1;
      ena_d[0] = 1'b0;
      #1;
      total++;
      if (rdata_o[0] !== 32'd0 || ack_o[0] !== 1'b0 || err_o[0] !== 1'b0 || stall_o[0] !== 1'b0 || err_o[2] !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_outputs: got rdata=%h ack=%b err=%b stall=%b err2=%b want all zero",
                  rdata_o[0], ack_o[0], err_o[0], stall_o[0], err_o[2]);
      end
      model_reset();
      @(negedge clka);
      rst = 1'b0;
      access(0, 4'h0, 32'h30, 32'h0, 0, 0, 0, 0, rd, er, at, sok);
      check_access("read_after_reset", 0, 0, rd, er, at, sok, 32'h0BADF00D, 1'b0);
   endtask

   task automatic test_reset_release();
      logic [31:0] rd; logic er; int at; bit sok;
      @(negedge clka);
      rst = 1'b1;
      ena_d[0] = 1'b1; wea_d[0] = 4'h0; addr_d[0] = 32'h10; wdata_d[0] = 32'h0;
      model_reset();
      @(negedge clka);
      #1;
      total++;
      if (ack_o[0] !== 1'b0 || stall_o[0] !== 1'b1) begin
         bad++;
         $display("FAIL reset_hold_request: got ack=%b stall=%b want ack=0 stall=1", ack_o[0], stall_o[0]);
      end
      @(negedge clka);
      rst = 1'b0;
      access(0, 4'h0, 32'h10, 32'h0, 0, 0, 0, 1, rd, er, at, sok);
      check_access("release_with_ena", 0, 0, rd, er, at, sok, 32'hDEADBEEF, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] rd; logic er; int at; bit sok;
      logic [31:0] a, wd;
      logic [3:0]  we;
      bit          keep, prev_keep;
      int          drop_k;
      for (int s = 0; s < 3; s++) begin
         for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            a  = {22'($urandom), 2'b00, 6'(w), 2'b00};
            access(s, 4'hF, a, wd, w > 0, w < 63, 0, 0, rd, er, at, sok);
            total++;
            if (at !== lat[s] + ((w > 0) ? 1 : 0) || sok !== 1'b1) begin
               bad++;
               $display("FAIL rand_fill timing dut%0d w%0d: got ack_at=%0d stall_ok=%b", s, w, at, sok);
            end
         end
         prev_keep = 1'b0;
         for (int n = 0; n < 60; n++) begin
            we     = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
            wd     = $urandom;
            a      = {22'($urandom), 2'b00, 6'($urandom), ($urandom % 5 == 0) ? 2'($urandom) : 2'b00};
            keep   = ($urandom % 3 == 0) && (n != 59);
            drop_k = (!keep && lat[s] > 1 && $urandom % 4 == 0) ? (prev_keep ? 2 : 1) : 0;
            access(s, we, a, wd, prev_keep, keep, drop_k, 0, rd, er, at, sok);
            total++;
            if (at !== lat[s] + (prev_keep ? 1 : 0) || sok !== 1'b1 || rd !== exp_rd[s] || er !== exp_er[s]) begin
               bad++;
               $display("FAIL rand dut%0d #%0d we=%h a=%h: got ack_at=%0d stall_ok=%b rdata=%h err=%b want ack_at=%0d rdata=%h err=%b",
                        s, n, we, a, at, sok, rd, er, lat[s] + (prev_keep ? 1 : 0), exp_rd[s], exp_er[s]);
            end
            prev_keep = keep;
         end
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_byte_enables();
      test_misaligned();
      test_wrap();
      test_latency_extremes();
      test_back_to_back();
      test_drop_while_busy();
      test_reset_mid_write();
      test_reset_release();
      test_random();
      repeat (2) @(negedge clka);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
